alu_register_file: RTL and testbench

ALU_REGISTER_FILE -- requirements
Module: alu_register_file

---
 rtl/alu_register_file_pkg.sv | 17 +
 rtl/alu_register_file_rv_regfile.sv | 57 +++++
 rtl/alu_register_file.sv | 69 ++++++
 tb/tb_alu_register_file.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_register_file_pkg.sv
// Shared widths and RV32I funct3 ALU operation codes for alu_register_file.
package alu_register_file_pkg;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 5;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/alu_register_file_rv_regfile.sv
// Two-read, one-write register file with hardwired-zero x0.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module rv_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic [ADDR_W-1:0] write_addr1,
    input  logic [XLEN-1:0]   write_data,
    input  logic              write_enable,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    assign wr_ok = write_enable && (write_addr1 != '0) && (int'(write_addr1) < NREGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[write_addr1] <= write_data;
        end
    end

    // Out-of-range indices (NREGS < 32) read as zero, same as x0.
    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != '0 && int'(addr) < NREGS) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && addr == write_addr1) begin
                val = write_data;
            end else begin
                val = regs[addr];
            end
`else
            val = regs[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        read_data1 = read_port(read_addr1);
        read_data2 = read_port(read_addr2);
    end

endmodule

// File: rtl/alu_register_file.sv
// RV32I-style register file plus combinational integer ALU (funct3/funct7[5] decode).
// Build option: REGFILE_BYPASS_EN forwards write_data to same-cycle reads of the written register.
module alu_register_file #(
    parameter int XLEN  = alu_register_file_pkg::XLEN,
    parameter int NREGS = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [alu_register_file_pkg::ADDR_W-1:0] read_addr1,
    input  logic [alu_register_file_pkg::ADDR_W-1:0] read_addr2,
    input  logic [alu_register_file_pkg::ADDR_W-1:0] write_addr1,
    input  logic [XLEN-1:0]                         write_data,
    input  logic                                    write_enable,
    output logic [XLEN-1:0]                         read_data1,
    output logic [XLEN-1:0]                         read_data2,
    input  logic [XLEN-1:0]                         alu_a,
    input  logic [XLEN-1:0]                         alu_b,
    input  logic [2:0]                              alu_op,
    input  logic [6:0]                              alu_funct7,
    output logic [XLEN-1:0]                         alu_out
);

    import alu_register_file_pkg::*;

    rv_regfile #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .write_addr1  (write_addr1),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHAMT_W-1:0]     shamt;
    logic                   alt;
    logic                   unused_funct7;

    assign a_s           = alu_a;
    assign b_s           = alu_b;
    assign shamt         = alu_b[SHAMT_W-1:0];
    assign alt           = alu_funct7[5];
    assign unused_funct7 = ^{alu_funct7[6], alu_funct7[4:0]};

    // funct7[5] selects SUB over ADD and SRA over SRL; other ops ignore it.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = alt ? (alu_a - alu_b) : (alu_a + alu_b);
            ALU_SLL:  alu_out = alu_a << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SR:   alu_out = alt ? $unsigned(a_s >>> shamt) : (alu_a >> shamt);
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
            default:  alu_out = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_register_file.sv
// Self-checking bench for alu_register_file: directed and random register-file and ALU tests
// against an arithmetic reference model.
module tb_alu_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_addr1, read_addr2, write_addr1;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data1, read_data2;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    alu_register_file dut (
        .clk          (clk),
        .reset        (reset),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .write_addr1  (write_addr1),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_funct7   (alu_funct7),
        .alu_out      (alu_out)
    );

    // Reference ALU from plain integer arithmetic on 32-bit values.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic alt);
        longint ua, ub, sa, sb, p, r;
        int sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
        sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
        sh = int'(b % 32);
        p  = 64'sd1 << sh;
        r  = 0;
        case (op)
            3'd0: r = alt ? (ua - ub + 64'sd4294967296) % 64'sd4294967296 : (ua + ub) % 64'sd4294967296;
            3'd1: r = (ua * p) % 64'sd4294967296;
            3'd2: r = (sa < sb) ? 1 : 0;
            3'd3: r = (ua < ub) ? 1 : 0;
            3'd4: r = ua ^ ub;
            3'd5: begin
                if (!alt)         r = ua / p;
                else if (sa >= 0) r = sa / p;
                else              r = -((-sa + p - 1) / p) + 64'sd4294967296;
            end
            3'd6: r = ua | ub;
            default: r = ua & ub;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        if (addr == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (write_enable && addr == write_addr1) return write_data;
`endif
        return model[addr];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        write_addr1  = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic check_reads(input string name, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] e1, e2;
        read_addr1 = a1;
        read_addr2 = a2;
        #1;
        e1 = ref_read(a1);
        e2 = ref_read(a2);
        n_tests++;
        if (read_data1 !== e1) begin
            n_fail++;
            $display("FAIL %s rd1 x%0d: got %08h expected %08h", name, a1, read_data1, e1);
        end
        n_tests++;
        if (read_data2 !== e2) begin
            n_fail++;
            $display("FAIL %s rd2 x%0d: got %08h expected %08h", name, a2, read_data2, e2);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int i = 0; i < 32; i++) check_reads("reset", 5'(i), 5'(31 - i));
    endtask

    task automatic test_x0;
        do_write(5'd0, 32'hDEADBEEF);
        check_reads("x0", 5'd0, 5'd0);
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'h00000007);
        check_reads("x5", 5'd5, 5'd5);
        write_addr1  = 5'd5;
        write_data   = 32'h1;
        write_enable = 1'b0;
        @(posedge clk);
        #1;
        check_reads("x5_noen", 5'd5, 5'd5);
    endtask

    task automatic test_bypass;
        logic [31:0] exp_v;
        do_write(5'd3, 32'h11111111);
        write_addr1  = 5'd3;
        write_data   = 32'h22222222;
        write_enable = 1'b1;
        read_addr1   = 5'd3;
        read_addr2   = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h22222222;
`else
        exp_v = 32'h11111111;
`endif
        n_tests++;
        if (read_data1 !== exp_v) begin
            n_fail++;
            $display("FAIL bypass x3: got %08h expected %08h", read_data1, exp_v);
        end
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        model[3] = 32'h22222222;
        check_reads("x3_after", 5'd3, 5'd3);
    endtask

    task automatic test_reset_priority;
        do_write(5'd4, 32'hCAFEF00D);
        check_reads("x4_pre", 5'd4, 5'd5);
        reset        = 1'b1;
        write_addr1  = 5'd4;
        write_data   = 32'h12345678;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        write_enable = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        check_reads("x4_rstprio", 5'd4, 5'd5);
    endtask

    task automatic test_regfile_random;
        for (int n = 0; n < 300; n++) begin
            write_addr1  = 5'($urandom_range(0, 31));
            write_data   = $urandom;
            write_enable = ($urandom_range(0, 3) != 0);
            check_reads("rand_rf", 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 3) == 0) ? write_addr1 : 5'($urandom_range(0, 31)));
            @(posedge clk);
            #1;
            if (write_enable && write_addr1 != 0) model[write_addr1] = write_data;
        end
        write_enable = 1'b0;
    endtask

    task automatic alu_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [6:0] f7, input logic [31:0] exp_v);
        alu_a = a; alu_b = b; alu_op = op; alu_funct7 = f7;
        #1;
        n_tests++;
        if (alu_out !== exp_v) begin
            n_fail++;
            $display("FAIL %s a=%08h b=%08h op=%0d f7=%02h: got %08h expected %08h",
                     name, a, b, op, f7, alu_out, exp_v);
        end
    endtask

    task automatic test_alu_directed;
        alu_check("add_wrap", 32'hFFFFFFFF, 32'h1, 3'b000, 7'h00, 32'h00000000);
        alu_check("sub",      32'hFFFFFFFF, 32'h1, 3'b000, 7'h20, 32'hFFFFFFFE);
        alu_check("slt",      32'hFFFFFFFF, 32'h1, 3'b010, 7'h00, 32'h00000001);
        alu_check("sltu",     32'hFFFFFFFF, 32'h1, 3'b011, 7'h00, 32'h00000000);
        alu_check("srl",      32'h80000000, 32'h24, 3'b101, 7'h00, 32'h08000000);
        alu_check("sra",      32'h80000000, 32'h24, 3'b101, 7'h20, 32'hF8000000);
        alu_check("sll",      32'h80000000, 32'h24, 3'b001, 7'h00, 32'h00000000);
        alu_check("xor",      32'hF0F0A5A5, 32'h0FF05A5A, 3'b100, 7'h00, 32'hFF00FFFF);
        alu_check("or",       32'hF0000001, 32'h0F000010, 3'b110, 7'h00, 32'hFF000011);
        alu_check("and",      32'hF0F0FFFF, 32'h0FF0000F, 3'b111, 7'h00, 32'h00F0000F);
        alu_check("slt_neg",  32'h00000001, 32'h80000000, 3'b010, 7'h00, 32'h00000000);
        alu_check("sltu_big", 32'h00000001, 32'h80000000, 3'b011, 7'h00, 32'h00000001);
    endtask

    task automatic test_alu_random;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [6:0]  f7;
        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            op = 3'($urandom_range(0, 7));
            f7 = 7'($urandom_range(0, 127));
            alu_check("rand_alu", a, b, op, f7, ref_alu(a, b, op, f7[5]));
        end
    endtask

    initial begin
        reset = 1'b1; read_addr1 = '0; read_addr2 = '0; write_addr1 = '0;
        write_data = '0; write_enable = 1'b0;
        alu_a = '0; alu_b = '0; alu_op = '0; alu_funct7 = '0;
        test_reset;
        test_x0;
        test_write_read;
        test_bypass;
        test_reset_priority;
        test_regfile_random;
        test_alu_directed;
        test_alu_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
